// File: rtl/seq_mul_n_pkg.sv
// Shared definitions for the parametrised shift-add multiplier:
// the controller state type and the iteration-counter width helper.
package seq_mul_pkg;

   // Controller states: wait for a request, iterate, then publish the product
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mulState_e;

   // Bits needed to count WIDTH iterations (0 .. WIDTH-1); never below one bit
   function automatic int cntWidth(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/seq_mul_n.sv
// Sequential shift-add multiplier with per-operation signed/unsigned mode.
// Operands are converted to magnitudes on capture, one multiplier bit is
// retired per clock, and the sign is re-applied on the publishing edge so
// the datapath itself only ever handles unsigned values.
module seq_mul_n
   import seq_mul_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] op
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = cntWidth(WIDTH);
   localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

   mulState_e        state_q, state_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic [PW-1:0]    mcandShift_q, mcandShift_d;
   logic [WIDTH-1:0] mplierShift_q, mplierShift_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             neg_q, neg_d;
   logic [PW-1:0]    op_q, op_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] magA, magB;

   // Operand magnitudes: in signed mode a negative operand is negated, so the
   // most negative value maps onto its exact unsigned magnitude 2^(WIDTH-1)
   always_comb begin
      magA = a;
      magB = b;
      if (signed_mode && a[WIDTH-1]) begin
         magA = -a;
      end
      if (signed_mode && b[WIDTH-1]) begin
         magB = -b;
      end
   end

   // Next-state and datapath: capture on request, shift-add while running,
   // apply the sign and raise the completion pulse on the publishing edge
   always_comb begin
      state_d       = state_q;
      acc_d         = acc_q;
      mcandShift_d  = mcandShift_q;
      mplierShift_d = mplierShift_q;
      cnt_d         = cnt_q;
      neg_d         = neg_q;
      op_d          = op_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               neg_d         = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
               mcandShift_d  = {{WIDTH{1'b0}}, magA};
               mplierShift_d = magB;
               acc_d         = '0;
               cnt_d         = '0;
               state_d       = RUN;
            end
         end
         RUN: begin
            if (mplierShift_q[0]) begin
               acc_d = acc_q + mcandShift_q;
            end
            mcandShift_d  = mcandShift_q << 1;
            mplierShift_d = mplierShift_q >> 1;
            cnt_d         = cnt_q + CW'(1);
            if (cnt_q == LastCnt) begin
               state_d = DONE;
            end
         end
         DONE: begin
            op_d    = neg_q ? (PW'(0) - acc_q) : acc_q;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_q == DONE);
   end

   // State and datapath registers; reset aborts any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         acc_q         <= '0;
         mcandShift_q  <= '0;
         mplierShift_q <= '0;
         cnt_q         <= '0;
         neg_q         <= 1'b0;
         op_q          <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         acc_q         <= acc_d;
         mcandShift_q  <= mcandShift_d;
         mplierShift_q <= mplierShift_d;
         cnt_q         <= cnt_d;
         neg_q         <= neg_d;
         op_q          <= op_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign op   = op_q;

endmodule

// File: tb/tb_seq_mul_n.sv
// Scoreboard bench for seq_mul_n: a 4-bit and an 8-bit instance share clock
// and reset. Stimulus pushes reference products; a monitor pops them on done.
module tb_seq_mul_n;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       start4 = 1'b0, sm4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic       busy4, done4;
   logic [7:0] op4;

   logic       start8 = 1'b0, sm8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       busy8, done8;
   logic [15:0] op8;

   int checks = 0;
   int errors = 0;

   logic [15:0] q4[$];
   logic [15:0] q8[$];
   logic [15:0] expOp[2];
   int          runLen[2];
   bit          prevBusy[2];

   // Free-running clock, 10 time units per period
   always #5 clk = ~clk;

   seq_mul_n #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(sm4),
      .a(a4), .b(b4), .busy(busy4), .done(done4), .op(op4)
   );

   seq_mul_n #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
      .a(a8), .b(b8), .busy(busy8), .done(done8), .op(op8)
   );

   function automatic int wOf(input int i);
      return (i == 0) ? 4 : 8;
   endfunction

   // Reference product: interpret operands as integers, multiply, wrap
   function automatic logic [15:0] refMul(input int w, input bit sgn, input int av, input int bv);
      longint x, y, p, mask;
      mask = (longint'(1) << w) - 1;
      x = longint'(av) & mask;
      y = longint'(bv) & mask;
      if (sgn && x >= (longint'(1) << (w - 1))) x = x - (longint'(1) << w);
      if (sgn && y >= (longint'(1) << (w - 1))) y = y - (longint'(1) << w);
      p = x * y;
      return 16'(p & ((longint'(1) << (2 * w)) - 1));
   endfunction

   task automatic getOut(input int i, output logic bz, output logic dn, output logic [15:0] o);
      if (i == 0) begin
         bz = busy4; dn = done4; o = {8'h00, op4};
      end else begin
         bz = busy8; dn = done8; o = op8;
      end
   endtask

   // Drive one request on instance i; push its product when it should be accepted
   task automatic applyStimulus(input int i, input bit sgn, input int av, input int bv, input bit accept);
      if (i == 0) begin
         start4 = 1'b1; sm4 = sgn; a4 = 4'(av); b4 = 4'(bv);
         if (accept) q4.push_back(refMul(4, sgn, av, bv));
      end else begin
         start8 = 1'b1; sm8 = sgn; a8 = 8'(av); b8 = 8'(bv);
         if (accept) q8.push_back(refMul(8, sgn, av, bv));
      end
      @(posedge clk);
      #1;
      if (i == 0) start4 = 1'b0;
      else        start8 = 1'b0;
   endtask

   // Return at the falling edge where done is seen, or flag a timeout
   task automatic waitDone(input int i);
      logic bz, dn;
      logic [15:0] o;
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 3 * wOf(i) + 10; k++) begin
         @(negedge clk);
         getOut(i, bz, dn, o);
         if (dn) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("[TB] FAIL doneTimeout w%0d: done not seen, required within %0d cycles", wOf(i), 3 * wOf(i) + 10);
      end
   endtask

   // Monitor one instance: reset values, product on done, handshake timing, op hold
   task automatic checkOutput(input int i);
      logic bz, dn;
      logic [15:0] o, exp;
      bit have;
      int w;
      w = wOf(i);
      getOut(i, bz, dn, o);
      if (!rst_n) begin
         if (i == 0) q4.delete();
         else        q8.delete();
         expOp[i]    = '0;
         runLen[i]   = 0;
         prevBusy[i] = 1'b0;
         checks++;
         if (bz !== 1'b0 || dn !== 1'b0 || o !== 16'h0) begin
            errors++;
            $display("[TB] FAIL resetState w%0d: busy=%b done=%b op=%h, required 0 0 0", w, bz, dn, o);
         end
         return;
      end
      if (dn === 1'b1) begin
         have = 1'b0;
         exp  = '0;
         if (i == 0 && q4.size() > 0) begin exp = q4.pop_front(); have = 1'b1; end
         if (i == 1 && q8.size() > 0) begin exp = q8.pop_front(); have = 1'b1; end
         checks++;
         if (!have) begin
            errors++;
            $display("[TB] FAIL unexpectedDone w%0d: op=%h, required no done", w, o);
         end else begin
            if (o !== exp) begin
               errors++;
               $display("[TB] FAIL product w%0d: op=%h, required %h", w, o, exp);
            end
            expOp[i] = exp;
         end
         checks++;
         if (!(prevBusy[i] && bz === 1'b0 && runLen[i] == w + 1)) begin
            errors++;
            $display("[TB] FAIL handshake w%0d: busyRun=%0d busyNow=%b, required busyRun=%0d busyNow=0", w, runLen[i], bz, w + 1);
         end
      end else begin
         checks++;
         if (o !== expOp[i]) begin
            errors++;
            $display("[TB] FAIL opHold w%0d: op=%h, required %h", w, o, expOp[i]);
         end
      end
      runLen[i]   = (bz === 1'b1) ? runLen[i] + 1 : 0;
      prevBusy[i] = (bz === 1'b1);
   endtask

   // Sample both instances away from the active edge
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) checkOutput(i);
   end

   initial begin
      int av, bv;
      bit sgn, ok;
      int idx;

      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);

      // Unsigned 4-bit products
      applyStimulus(0, 1'b0, 3, 5, 1'b1);  waitDone(0); @(negedge clk);
      applyStimulus(0, 1'b0, 9, 2, 1'b1);  waitDone(0); @(negedge clk);
      applyStimulus(0, 1'b0, 7, 7, 1'b1);  waitDone(0); @(negedge clk);

      // Signed and unsigned 8-bit products including the most negative square
      applyStimulus(1, 1'b1, -3, 5, 1'b1);     waitDone(1); @(negedge clk);
      applyStimulus(1, 1'b1, -128, -128, 1'b1); waitDone(1); @(negedge clk);
      applyStimulus(1, 1'b1, 127, -1, 1'b1);   waitDone(1); @(negedge clk);
      applyStimulus(1, 1'b0, 8'hFD, 5, 1'b1);  waitDone(1); @(negedge clk);

      // A request during an operation must be ignored
      applyStimulus(1, 1'b0, 6, 7, 1'b1);
      repeat (2) @(negedge clk);
      applyStimulus(1, 1'b0, 2, 2, 1'b0);
      waitDone(1);
      repeat (12) @(negedge clk);

      // Back-to-back: next request issued in the done cycle
      applyStimulus(0, 1'b0, 15, 15, 1'b1); waitDone(0);
      applyStimulus(0, 1'b0, 10, 10, 1'b1); waitDone(0);
      @(negedge clk);

      // Asynchronous reset in the middle of an operation
      applyStimulus(1, 1'b0, 200, 201, 1'b1);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (busy8 !== 1'b0 || done8 !== 1'b0 || op8 !== 16'h0) begin
         errors++;
         $display("[TB] FAIL asyncReset: busy=%b done=%b op=%h, required 0 0 0", busy8, done8, op8);
      end
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (14) @(negedge clk);
      applyStimulus(1, 1'b0, 4, 4, 1'b1); waitDone(1); @(negedge clk);

      // Operands and mode wiggle while running
      applyStimulus(1, 1'b1, $urandom_range(0, 255), $urandom_range(0, 255), 1'b1);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
      end
      waitDone(1); @(negedge clk);

      // Randomized traffic with random gaps, gap 0 being back-to-back
      for (int n = 0; n < 60; n++) begin
         idx = $urandom_range(0, 1);
         sgn = 1'($urandom);
         av  = $urandom_range(0, (1 << wOf(idx)) - 1);
         bv  = $urandom_range(0, (1 << wOf(idx)) - 1);
         applyStimulus(idx, sgn, av, bv, 1'b1);
         waitDone(idx);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // Drain: every pushed product must have been retired
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (q4.size() == 0 && q8.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL drain: pending=%0d, required 0", q4.size() + q8.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
